// File: rtl/key_debounce_pulse.sv
// Pushbutton debouncer: 2-flop synchronizer feeding a four-state debounce FSM
// that produces a clean level plus one-cycle press and release strobes.
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_pulse,
  output logic key_release
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_t;

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE_RAW = (ACTIVE_LOW != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             sync2;
  logic             p;

  // Synchronizer flops reset to the idle level so a held key is re-debounced after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign p = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RELEASED;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        RELEASED: begin
          if (p) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!p) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            key_level <= 1'b1;
            key_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
          // key_level stays high here; it only drops once the release is accepted.
          if (p) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Randomized scoreboard bench for key_debounce_pulse (N=4, active-low key).
module tb_key_debounce_pulse;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_in = 1'b1;
  logic key_level;
  logic key_pulse;
  logic key_release;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .key_level(key_level),
    .key_pulse(key_pulse),
    .key_release(key_release)
  );

  logic [2:0] expq[$];
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int releases = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: the debounced level flips once the synchronized key has
  // disagreed with it for N+1 consecutive clocks; the flip cycle carries the strobe.
  bit     m_hist[$];
  bit     m_lvl = 1'b0;
  int     m_run = 0;
  always @(posedge clk) begin
    bit p;
    bit pls;
    bit rel;
    pls = 1'b0;
    rel = 1'b0;
    if (reset) begin
      m_hist = {1'b0, 1'b0};
      m_lvl  = 1'b0;
      m_run  = 0;
    end else begin
      p = m_hist.pop_front();
      m_hist.push_back(~key_in);
      if (p != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == N + 1) begin
        m_lvl = p;
        pls   = p;
        rel   = ~p;
        m_run = 0;
      end
    end
    expq.push_back({m_lvl, pls, rel});
  end

  // Monitor: compares every presented output cycle against the scoreboard.
  logic prev_strobe = 1'b0;
  always @(posedge clk) begin
    logic [2:0] e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("outputs{level,pulse,release}", {29'b0, key_level, key_pulse, key_release}, {29'b0, e});
      checkOutput("pulse_release_overlap", {31'b0, key_pulse & key_release}, 32'd0);
      checkOutput("strobe_back_to_back", {31'b0, prev_strobe & (key_pulse | key_release)}, 32'd0);
      prev_strobe = key_pulse | key_release;
      if (key_pulse === 1'b1) pulses++;
      if (key_release === 1'b1) releases++;
    end
  end

  task automatic applyStimulus(input logic lvl, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      key_in = lvl;
    end
  endtask

  initial begin
    int p0;
    int r0;
    int len;
    logic lvl;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Clean press and release
    p0 = pulses;
    applyStimulus(1'b0, 12);
    checkOutput("press_pulse_count", pulses - p0, 1);
    checkOutput("press_level", {31'b0, key_level}, 32'd1);
    applyStimulus(1'b1, 12);

    // Short press: no strobe, level stays low
    p0 = pulses;
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 10);
    checkOutput("short_press_pulses", pulses - p0, 0);
    checkOutput("short_press_level", {31'b0, key_level}, 32'd0);

    // Release with a one-cycle glitch inside the window
    applyStimulus(1'b0, 12);
    p0 = pulses;
    r0 = releases;
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 12);
    checkOutput("glitch_release_count", releases - r0, 1);
    checkOutput("glitch_release_pulses", pulses - p0, 0);

    // Reset mid-debounce with key held
    applyStimulus(1'b1, 10);
    p0 = pulses;
    applyStimulus(1'b0, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 12);
    checkOutput("reset_rearm_pulses", pulses - p0, 1);
    applyStimulus(1'b1, 12);

    // Five clean press/release cycles
    p0 = pulses;
    r0 = releases;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 10);
      applyStimulus(1'b1, 10);
    end
    checkOutput("five_cycle_pulses", pulses - p0, 5);
    checkOutput("five_cycle_releases", releases - r0, 5);

    // Randomized bouncing with occasional reset
    for (int k = 0; k < 400; k++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      applyStimulus(lvl, len);
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    applyStimulus(1'b1, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce_pulse.md
KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the stable-input cycle count N required to accept a change; legal range 2..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 16, SHALL set the debounce counter width.
REQ-004 Parameter ACTIVE_LOW, default 1, SHALL mark key_in as pressed-when-0 if 1, pressed-when-1 if 0.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 key_in  input  1  raw asynchronous pushbutton/switch level.
REQ-008 key_level  output  1  debounced level; 1 = pressed.
REQ-009 key_pulse  output  1  one-cycle strobe on each accepted press; drives the downstream FSM x input.
REQ-010 key_release  output  1  one-cycle strobe on each accepted release.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer; only the second flop output, normalized by ACTIVE_LOW to p (1 = pressed), SHALL feed the FSM.
REQ-012 FSM states SHALL be RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK, with a CNT_W-bit counter cnt.
REQ-013 RELEASED: p=1 -> PRESS_CHK with cnt<=0; else stay.
REQ-014 PRESS_CHK: p=0 -> RELEASED, cnt<=0, no strobe; p=1 and cnt<N-1 -> cnt<=cnt+1; p=1 and cnt==N-1 -> PRESSED.
REQ-015 PRESSED: p=0 -> RELEASE_CHK with cnt<=0; else stay.
REQ-016 RELEASE_CHK: p=1 -> PRESSED, cnt<=0, no strobe; p=0 and cnt<N-1 -> cnt<=cnt+1; p=0 and cnt==N-1 -> RELEASED.
REQ-017 key_level SHALL be registered, 1 exactly while state is PRESSED or RELEASE_CHK.
REQ-018 key_pulse SHALL be registered and high for exactly the one cycle following the PRESS_CHK->PRESSED edge.
REQ-019 key_release SHALL be registered and high for exactly the one cycle following the RELEASE_CHK->RELEASED edge.
REQ-020 Latency: key_in stably pressed from rising edge E0 SHALL set key_level and key_pulse after edge E(N+2); release is symmetric for key_level/key_release.
REQ-021 Any input glitch shorter than N+1 synchronized cycles SHALL produce no strobe and no key_level change.
REQ-022 key_pulse and key_release SHALL never be high in the same cycle; strobes SHALL never be high for two consecutive cycles.
REQ-023 cnt SHALL never exceed N-1 and SHALL not wrap.

Reset
REQ-024 reset=1 at a clk edge SHALL force state RELEASED, cnt=0, both synchronizer flops to the not-pressed value, key_level=0, key_pulse=0, key_release=0, taking priority over all other conditions.
REQ-025 Reset mid-debounce or while PRESSED SHALL discard progress with no strobe; a key held through reset release SHALL be re-debounced from scratch and yield one key_pulse after full latency.

Verification (N=4, ACTIVE_LOW=1)
REQ-026 Reset then key_in=0 held from E0 -> key_level=1 and key_pulse=1 after E6, key_pulse=0 after E7, key_level stays 1.
REQ-027 key_in=0 for 3 cycles then 1 -> key_pulse never 1, key_level stays 0.
REQ-028 Pressed steady, then key_in=1 with one 1-cycle 0 glitch inside the window -> counting restarts; key_release exactly once, N+2 edges after the final stable rise; no key_pulse.
REQ-029 Pressed steady, reset=1 for one cycle at E(N) mid-PRESS_CHK with key still 0 -> outputs 0 during reset; one key_pulse N+3 edges after reset release.
REQ-030 Five clean press/release cycles, each phase 10 cycles -> exactly five key_pulse and five key_release strobes, never overlapping.
